hawk_axiwr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single HAWK AXI write master between NUM_REQ write

---
 rtl/hawk_axiwr_pkg.sv | 37 +++
 rtl/hawk_axiwr_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_hawk_axiwr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hawk_axiwr_pkg.sv
// -----------------------------------------------------------------------------
// hawk_axiwr_pkg
// Shared types for the HAWK AXI write path.
//   axi_wr_pld_t      : one write request payload (addr, 512b data, byte strobes)
//   axi_wr_reqpkt_t   : payload plus AW/W valids, driven towards the AXI write master
//   axi_wr_rdypkt_t   : AW/W ready returned by the AXI write master
//   axi_wr_resppkt_t  : B-channel response (bresp, bvalid)
// -----------------------------------------------------------------------------
package hawk_axiwr_pkg;

    localparam int PLD_W = 640;

    typedef struct packed {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
    } axi_wr_pld_t;

    typedef struct packed {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
        logic         awvalid;
        logic         wvalid;
    } axi_wr_reqpkt_t;

    typedef struct packed {
        logic awready;
        logic wready;
    } axi_wr_rdypkt_t;

    typedef struct packed {
        logic [1:0] bresp;
        logic       bvalid;
    } axi_wr_resppkt_t;

endpackage

// File: rtl/hawk_axiwr_arbiter.sv
// -----------------------------------------------------------------------------
// hawk_axiwr_arbiter
// Round-robin arbiter sharing the single HAWK AXI write master between NUM_REQ
// write requesters. One single-beat AW+W transaction outstanding at a time; the
// B response is routed back to the requester that owns it.
//
// Optional feature macro: HAWK_WRARB_TIMEOUT_EN
//   defined   : B-response watchdog of TIMEOUT_CYCLES cycles, completes the
//               transaction with SLVERR and sets sticky timeout_o.
//   undefined : WAIT_B waits indefinitely, timeout_o tied low.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   req_valid_i   per-requester write pending
//   req_pld_i     per-requester axi_wr_pld_t, slot i at [640*i +: 640]
//   req_ready_o   one-hot accept pulse (payload captured that cycle)
//   done_o        one-hot completion pulse to the owner
//   done_bresp_o  bresp of the completing transaction, valid with done_o
//   wr_reqpkt_o   addr/data/strb/awvalid/wvalid to the AXI write master
//   bready_o      B-channel ready
//   wr_rdypkt_i   awready/wready
//   wr_resppkt_i  bresp/bvalid
//   timeout_o     sticky watchdog flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | searching for a requester from rr_ptr; grant and capture
// ISSUE   | AW and W valid until each channel has handshaken
// WAIT_B  | bready high, waiting for the B response (or watchdog)
// -----------------------------------------------------------------------------
module hawk_axiwr_arbiter
    import hawk_axiwr_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*PLD_W-1:0] req_pld_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic [1:0]               done_bresp_o,
    output axi_wr_reqpkt_t           wr_reqpkt_o,
    output logic                     bready_o,
    input  axi_wr_rdypkt_t           wr_rdypkt_i,
    input  axi_wr_resppkt_t          wr_resppkt_i,
    output logic                     timeout_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_B = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_gnt_idx;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_ptr_after;
    logic             w_gnt_found;
    axi_wr_pld_t      r_pld;
    logic             r_awvalid;
    logic             r_wvalid;
    logic             w_aw_clr;
    logic             w_w_clr;
    logic             w_take;
    logic             w_retire;
    logic             w_to_fire;
    axi_wr_pld_t      w_slot [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        assign w_slot[gi] = req_pld_i[PLD_W*gi +: PLD_W];
    end

    // Rotating search starting at rr_ptr; the wrap is against NUM_REQ, so a
    // non-power-of-2 requester count never indexes a missing slot.
    always_comb begin
        logic [PTR_W:0]   v_idx;
        logic [PTR_W-1:0] v_pos;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        v_idx       = '0;
        v_pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (v_idx >= (PTR_W+1)'(NUM_REQ)) begin
                v_idx = v_idx - (PTR_W+1)'(NUM_REQ);
            end
            v_pos = v_idx[PTR_W-1:0];
            if (!w_gnt_found && req_valid_i[v_pos]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = v_pos;
            end
        end
    end

    assign w_ptr_after = (r_gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : r_gnt_idx + PTR_W'(1);

    // A channel counts as complete if it already handshook or handshakes now.
    assign w_aw_clr = !r_awvalid || wr_rdypkt_i.awready;
    assign w_w_clr  = !r_wvalid  || wr_rdypkt_i.wready;

`ifdef HAWK_WRARB_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_timeout;

    // Counts cycles spent in WAIT_B; held at zero elsewhere so every entry starts fresh.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != ST_WAIT_B) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end
            if (w_to_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // A real bvalid in the same cycle wins over the watchdog.
    assign w_to_fire = (r_state == ST_WAIT_B) && !wr_resppkt_i.bvalid
                       && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign timeout_o = r_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_to_fire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        req_ready_o  = '0;
        done_o       = '0;
        done_bresp_o = 2'b00;
        w_take       = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_found) begin
                    req_ready_o[w_gnt_idx] = 1'b1;
                    w_take                 = 1'b1;
                    w_state_nxt            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_aw_clr && w_w_clr) begin
                    w_state_nxt = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (wr_resppkt_i.bvalid) begin
                    done_o[r_gnt_idx] = 1'b1;
                    done_bresp_o      = wr_resppkt_i.bresp;
                    w_retire          = 1'b1;
                    w_state_nxt       = ST_IDLE;
                end else if (w_to_fire) begin
                    done_o[r_gnt_idx] = 1'b1;
                    done_bresp_o      = 2'b10;
                    w_retire          = 1'b1;
                    w_state_nxt       = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // The transaction being abandoned by reset must not report completion or accept.
        if (rst_i) begin
            req_ready_o  = '0;
            done_o       = '0;
            done_bresp_o = 2'b00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_pld     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_pld     <= w_slot[w_gnt_idx];
                r_gnt_idx <= w_gnt_idx;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
            end else begin
                if (r_awvalid && wr_rdypkt_i.awready) begin
                    r_awvalid <= 1'b0;
                end
                if (r_wvalid && wr_rdypkt_i.wready) begin
                    r_wvalid <= 1'b0;
                end
            end
            if (w_retire) begin
                r_rr_ptr <= w_ptr_after;
            end
        end
    end

    assign wr_reqpkt_o.addr    = r_pld.addr;
    assign wr_reqpkt_o.data    = r_pld.data;
    assign wr_reqpkt_o.strb    = r_pld.strb;
    assign wr_reqpkt_o.awvalid = r_awvalid;
    assign wr_reqpkt_o.wvalid  = r_wvalid;
    assign bready_o            = (r_state == ST_WAIT_B);

endmodule

// File: tb/tb_hawk_axiwr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hawk_axiwr_arbiter
// Directed bench for hawk_axiwr_arbiter with NUM_REQ=3, TIMEOUT_CYCLES=16.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_hawk_axiwr_arbiter;
    import hawk_axiwr_pkg::*;

    localparam int NR = 3;
    localparam int TO = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NR-1:0]        req_valid_i;
    logic [NR*PLD_W-1:0]  req_pld_i;
    logic [NR-1:0]        req_ready_o;
    logic [NR-1:0]        done_o;
    logic [1:0]           done_bresp_o;
    axi_wr_reqpkt_t       wr_reqpkt_o;
    logic                 bready_o;
    axi_wr_rdypkt_t       wr_rdypkt_i;
    axi_wr_resppkt_t      wr_resppkt_i;
    logic                 timeout_o;

    int n_tot = 0;
    int n_bad = 0;

    localparam logic [511:0] DATA1 = {64'hDEAD_BEEF_0000_0007, {6{64'h0}}, 64'h0123_4567_89AB_CDEF};

    hawk_axiwr_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_pld_i    (req_pld_i),
        .req_ready_o  (req_ready_o),
        .done_o       (done_o),
        .done_bresp_o (done_bresp_o),
        .wr_reqpkt_o  (wr_reqpkt_o),
        .bready_o     (bready_o),
        .wr_rdypkt_i  (wr_rdypkt_i),
        .wr_resppkt_i (wr_resppkt_i),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_rdy(input logic aw, input logic w);
        wr_rdypkt_i.awready = aw;
        wr_rdypkt_i.wready  = w;
    endtask

    task automatic set_b(input logic v, input logic [1:0] r);
        wr_resppkt_i.bvalid = v;
        wr_resppkt_i.bresp  = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int early;
        logic [NR-1:0] g;
        req_valid_i  = '0;
        req_pld_i    = '0;
        wr_rdypkt_i  = '0;
        wr_resppkt_i = '0;
        req_pld_i[0*PLD_W +: PLD_W] = {64'h0000_0000_0000_1000, 512'h11, 64'h0000_0000_0000_00FF};
        req_pld_i[1*PLD_W +: PLD_W] = {64'h0000_00FF_F620_0040, DATA1, {64{1'b1}}};
        req_pld_i[2*PLD_W +: PLD_W] = {64'h0000_0000_0000_2000, 512'h22, 64'h0000_0000_0000_000F};

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_ready",   64'(req_ready_o), 64'h0);
        check("rst_valids",  64'({wr_reqpkt_o.awvalid, wr_reqpkt_o.wvalid}), 64'h0);
        check("rst_bready",  64'(bready_o), 64'h0);
        check("rst_done",    64'(done_o), 64'h0);
        check("rst_timeout", 64'(timeout_o), 64'h0);
        check("rst_addr",    wr_reqpkt_o.addr, 64'h0);

        // T1 single transaction, requester 1, instant ready
        req_valid_i = 3'b010;
        set_rdy(1'b1, 1'b1);
        #1;
        check("t1_ready", 64'(req_ready_o), 64'h2);
        nxt();
        req_valid_i = '0;
        #1;
        check("t1_c1_valids", 64'({wr_reqpkt_o.awvalid, wr_reqpkt_o.wvalid}), 64'h3);
        check("t1_addr",      wr_reqpkt_o.addr, 64'h0000_00FF_F620_0040);
        check("t1_strb",      wr_reqpkt_o.strb, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_data_lo",   wr_reqpkt_o.data[63:0], 64'h0123_4567_89AB_CDEF);
        check("t1_data_hi",   wr_reqpkt_o.data[511:448], 64'hDEAD_BEEF_0000_0007);
        check("t1_c1_ready",  64'(req_ready_o), 64'h0);
        nxt();
        #1;
        check("t1_c2_valids", 64'({wr_reqpkt_o.awvalid, wr_reqpkt_o.wvalid}), 64'h0);
        check("t1_c2_bready", 64'(bready_o), 64'h1);
        check("t1_c2_done",   64'(done_o), 64'h0);
        nxt();
        set_b(1'b1, 2'b00);
        #1;
        check("t1_done",  64'(done_o), 64'h2);
        check("t1_bresp", 64'(done_bresp_o), 64'h0);
        nxt();
        set_b(1'b0, 2'b00);
        #1;
        check("t1_done_clr",   64'(done_o), 64'h0);
        check("t1_bready_clr", 64'(bready_o), 64'h0);

        // T2 split handshake, requester 0 (rr_ptr=2 wraps to 0)
        set_rdy(1'b0, 1'b0);
        req_valid_i = 3'b001;
        #1;
        check("t2_ready", 64'(req_ready_o), 64'h1);
        nxt();
        req_valid_i = '0;
        set_rdy(1'b0, 1'b1);
        #1;
        check("t2_c1_valids", 64'({wr_reqpkt_o.awvalid, wr_reqpkt_o.wvalid}), 64'h3);
        nxt();
        set_rdy(1'b0, 1'b0);
        #1;
        check("t2_c2_valids", 64'({wr_reqpkt_o.awvalid, wr_reqpkt_o.wvalid}), 64'h2);
        check("t2_c2_bready", 64'(bready_o), 64'h0);
        nxt();
        #1;
        check("t2_c3_valids", 64'({wr_reqpkt_o.awvalid, wr_reqpkt_o.wvalid}), 64'h2);
        nxt();
        set_rdy(1'b1, 1'b0);
        #1;
        check("t2_c4_valids", 64'({wr_reqpkt_o.awvalid, wr_reqpkt_o.wvalid}), 64'h2);
        check("t2_c4_addr",   wr_reqpkt_o.addr, 64'h1000);
        nxt();
        set_rdy(1'b0, 1'b0);
        set_b(1'b1, 2'b01);
        #1;
        check("t2_c5_valids", 64'({wr_reqpkt_o.awvalid, wr_reqpkt_o.wvalid}), 64'h0);
        check("t2_c5_bready", 64'(bready_o), 64'h1);
        check("t2_done",      64'(done_o), 64'h1);
        check("t2_bresp",     64'(done_bresp_o), 64'h1);
        nxt();
        set_b(1'b0, 2'b00);
        #1;
        check("t2_done_clr", 64'(done_o), 64'h0);

        // reset returns rr_ptr to 0 for the round-robin run
        rst_i = 1'b1;
        nxt();
        rst_i = 1'b0;

        // T3 all requesting, instant ready/bvalid: grants 0,1,2,0
        req_valid_i = 3'b111;
        set_rdy(1'b1, 1'b1);
        set_b(1'b1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            g = NR'(1) << (k % NR);
            #1;
            check("t3_grant", 64'(req_ready_o), 64'(g));
            nxt();
            #1;
            check("t3_issue_ready", 64'(req_ready_o), 64'h0);
            check("t3_issue_done",  64'(done_o), 64'h0);
            nxt();
            #1;
            check("t3_wait_ready", 64'(req_ready_o), 64'h0);
            check("t3_done",       64'(done_o), 64'(g));
            nxt();
        end
        req_valid_i = '0;
        set_rdy(1'b0, 1'b0);
        set_b(1'b0, 2'b00);
        #1;
        check("t3_idle_ready", 64'(req_ready_o), 64'h0);

        // T4 grant 1 moves rr_ptr to 2; then 3'b011 gives 0 then 1
        req_valid_i = 3'b010;
        set_rdy(1'b1, 1'b1);
        set_b(1'b1, 2'b00);
        #1;
        check("t4_g1", 64'(req_ready_o), 64'h2);
        nxt();
        req_valid_i = '0;
        nxt();
        #1;
        check("t4_g1_done", 64'(done_o), 64'h2);
        nxt();
        req_valid_i = 3'b011;
        #1;
        check("t4_g0", 64'(req_ready_o), 64'h1);
        nxt();
        req_valid_i = 3'b010;
        #1;
        check("t4_issue_ready", 64'(req_ready_o), 64'h0);
        nxt();
        #1;
        check("t4_g0_done", 64'(done_o), 64'h1);
        nxt();
        #1;
        check("t4_g1b", 64'(req_ready_o), 64'h2);
        nxt();
        req_valid_i = '0;
        nxt();
        #1;
        check("t4_g1b_done", 64'(done_o), 64'h2);
        nxt();
        set_rdy(1'b0, 1'b0);
        set_b(1'b0, 2'b00);

        // T5 reset while AW is stalled; rr_ptr was 2 and must restart at 0
        req_valid_i = 3'b100;
        #1;
        check("t5_g2", 64'(req_ready_o), 64'h4);
        nxt();
        req_valid_i = '0;
        #1;
        check("t5_awvalid", 64'(wr_reqpkt_o.awvalid), 64'h1);
        rst_i = 1'b1;
        nxt();
        rst_i = 1'b0;
        #1;
        check("t5_valids", 64'({wr_reqpkt_o.awvalid, wr_reqpkt_o.wvalid}), 64'h0);
        check("t5_bready", 64'(bready_o), 64'h0);
        check("t5_done",   64'(done_o), 64'h0);
        nxt();
        req_valid_i = 3'b101;
        #1;
        check("t5_from0", 64'(req_ready_o), 64'h1);
        nxt();
        req_valid_i = '0;
        set_rdy(1'b1, 1'b1);
        nxt();
        set_rdy(1'b0, 1'b0);
        set_b(1'b1, 2'b00);
        #1;
        check("t5_done0", 64'(done_o), 64'h1);
        nxt();
        set_b(1'b0, 2'b00);

        // T6 no B response, requester 1 (rr_ptr=1)
        req_valid_i = 3'b010;
        #1;
        check("t6_ready", 64'(req_ready_o), 64'h2);
        nxt();
        req_valid_i = '0;
        set_rdy(1'b1, 1'b1);
        nxt();
        set_rdy(1'b0, 1'b0);
        early = 0;
`ifdef HAWK_WRARB_TIMEOUT_EN
        for (int k = 0; k < TO - 1; k++) begin
            #1;
            if (done_o != '0) early++;
            nxt();
        end
        #1;
        check("t6_early",    64'(early), 64'h0);
        check("t6_to_done",  64'(done_o), 64'h2);
        check("t6_to_bresp", 64'(done_bresp_o), 64'h2);
        nxt();
        #1;
        check("t6_timeout", 64'(timeout_o), 64'h1);
        check("t6_bready",  64'(bready_o), 64'h0);
        set_b(1'b1, 2'b00);
        #1;
        check("t6_late_done", 64'(done_o), 64'h0);
        nxt();
        set_b(1'b0, 2'b00);
        #1;
        check("t6_sticky", 64'(timeout_o), 64'h1);
`else
        for (int k = 0; k < 40; k++) begin
            #1;
            if (done_o != '0) early++;
            nxt();
        end
        #1;
        check("t6_no_done", 64'(early), 64'h0);
        check("t6_bready",  64'(bready_o), 64'h1);
        check("t6_timeout", 64'(timeout_o), 64'h0);
        set_b(1'b1, 2'b11);
        #1;
        check("t6_done",  64'(done_o), 64'h2);
        check("t6_bresp", 64'(done_bresp_o), 64'h3);
        nxt();
        set_b(1'b0, 2'b00);
        #1;
        check("t6_bready_clr", 64'(bready_o), 64'h0);
        check("t6_timeout_0",  64'(timeout_o), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
